// File: rtl/factorial_top.sv
// factorial_top: iterative n! mod 2^SIZE engine (FSM controller + counter/product datapath)
module factorial_top #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic [SIZE-1:0] n,
    output logic [2:0]      curr_state,
    output logic            done,
    output logic [SIZE-1:0] result,
    output logic            proceed
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] MULT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]      state, next_state;
    logic [SIZE-1:0] counter, product;

    assign proceed    = counter > SIZE'(1);
    assign done       = state == DONE;
    assign result     = product;
    assign curr_state = state;

    // codes 5-7 fall through to IDLE
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:  next_state = go ? LOAD : IDLE;
            LOAD:  next_state = CHECK;
            CHECK: next_state = proceed ? MULT : DONE;
            MULT:  next_state = CHECK;
            DONE:  next_state = go ? DONE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            product <= '0;
        end else begin
            state <= next_state;
            if (state == LOAD) begin
                counter <= n;
                product <= SIZE'(1);
            end else if (state == MULT) begin
                product <= product * counter;
                counter <= counter - SIZE'(1);
            end
        end
    end
endmodule

// File: tb/tb_factorial_top.sv
// tb_factorial_top: directed + randomized checks of factorial_top against an arithmetic model
module tb_factorial_top;
    localparam int SIZE = 8;

    logic            clk = 0;
    logic            rst_n = 0;
    logic            go = 0;
    logic [SIZE-1:0] n = '0;
    logic [2:0]      curr_state;
    logic            done;
    logic [SIZE-1:0] result;
    logic            proceed;

    int checks = 0;
    int failures = 0;

    factorial_top #(.SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .n(n),
        .curr_state(curr_state), .done(done), .result(result), .proceed(proceed)
    );

    always #5 clk = ~clk;

    function automatic int fact_mod(input int k);
        int p = 1;
        for (int i = 2; i <= k; i++) p = (p * i) % (1 << SIZE);
        return p;
    endfunction

    function automatic int exp_latency(input int k);
        return (k <= 1) ? 3 : 2 * (k - 1) + 3;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Launch a computation, optionally scrambling go/n once it is underway, then release go.
    task automatic run(input int nv, input bit scramble);
        int edges = 0;
        bit seen = 0;
        @(negedge clk);
        go = 1;
        n = SIZE'(nv);
        while (!seen && edges < 600) begin
            @(posedge clk);
            #1;
            edges++;
            seen = done;
            if (nv <= 1) chk("proceed_small_n", int'(proceed), 0);
            if (scramble && !seen) begin
                go = 1'($urandom);
                if (edges >= 2) n = SIZE'($urandom);
            end
        end
        chk($sformatf("latency_n%0d", nv), edges, exp_latency(nv));
        chk($sformatf("result_n%0d", nv), int'(result), fact_mod(nv));
        @(negedge clk);
        go = 0;
        @(posedge clk);
        #1;
        chk("idle_after_release", int'(curr_state), 0);
        chk("done_low_after_release", int'(done), 0);
        chk("result_held_in_idle", int'(result), fact_mod(nv));
    endtask

    initial begin
        int exp_states[$];
        int lim;
        // reset values
        #12;
        chk("reset_state", int'(curr_state), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_proceed", int'(proceed), 0);
        @(negedge clk);
        rst_n = 1;

        // n=5 with go held: state trace, then hold DONE for 100 cycles
        exp_states.push_back(1);
        lim = 4;
        for (int i = 0; i < lim; i++) begin
            exp_states.push_back(2);
            exp_states.push_back(3);
        end
        exp_states.push_back(2);
        exp_states.push_back(4);
        @(negedge clk);
        go = 1;
        n = 8'd5;
        foreach (exp_states[i]) begin
            @(posedge clk);
            #1;
            chk($sformatf("trace_edge%0d", i + 1), int'(curr_state), exp_states[i]);
        end
        chk("n5_done", int'(done), 1);
        chk("n5_result", int'(result), 120);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            chk("hold_done", int'(done), 1);
            chk("hold_result", int'(result), 120);
        end
        @(negedge clk);
        go = 0;
        @(posedge clk);
        #1;
        chk("drop_go_state", int'(curr_state), 0);
        chk("drop_go_done", int'(done), 0);
        chk("drop_go_result", int'(result), 120);

        // boundary and directed operands
        run(0, 0);
        run(1, 0);
        run(6, 0);
        run(3, 0);
        run(4, 0);

        // async reset in the middle of a run
        @(negedge clk);
        go = 1;
        n = 8'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_mult", int'(curr_state), 3);
        #2;
        rst_n = 0;
        #1;
        chk("midreset_state", int'(curr_state), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_result", int'(result), 0);
        @(negedge clk);
        rst_n = 1;
        go = 0;
        run(5, 0);

        // go/n disturbance during the loop must be ignored
        run(7, 1);
        run(5, 1);

        // randomized operands
        for (int i = 0; i < 20; i++) begin
            run((i % 4 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
